// File: rtl/maj_voter_n.sv
// maj_voter_n: N-way bitwise majority voter with per-channel mismatch, fault streaks and a saturating disagreement count.
// Latency: 1 cycle from in_valid to out_valid. Backpressure: none; a vote is accepted every cycle.
// Optional MAJ_VOTER_STICKY_FAULT_EN: fault bits latch until clr_fault or reset.
module maj_voter_n #(
  parameter int N            = 3,
  parameter int W            = 8,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic             clr_fault,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [N-1:0]     mismatch,
  output logic [N-1:0]     fault,
  output logic [CNT_W-1:0] disagree_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(FAULT_THRESH + 1);
  localparam logic [CW-1:0]    QUORUM  = CW'((N + 1) / 2);
  localparam logic [SW-1:0]    THRESH  = SW'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (N < 3 || (N % 2) == 0) begin : g_bad_n
    $error("maj_voter_n: N must be odd and >= 3");
  end
  if (W < 1 || FAULT_THRESH < 1 || CNT_W < 1) begin : g_bad_param
    $error("maj_voter_n: W, FAULT_THRESH and CNT_W must be >= 1");
  end

  logic [W-1:0]     voted;
  logic [CW-1:0]    ones;
  logic [N-1:0]     mm_nxt;
  logic [SW-1:0]    streak_q   [N];
  logic [SW-1:0]    streak_nxt [N];
  logic [N-1:0]     fault_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Per-bit population count against the quorum.
  always_comb begin
    voted = '0;
    ones  = '0;
    for (int b = 0; b < W; b++) begin
      ones = '0;
      for (int i = 0; i < N; i++) begin
        ones = ones + CW'(in_data[i*W+b]);
      end
      voted[b] = (ones >= QUORUM);
    end
  end

  always_comb begin
    mm_nxt = '0;
    for (int i = 0; i < N; i++) begin
      mm_nxt[i] = (in_data[i*W +: W] != voted);
    end
  end

  // Idle cycles hold the streak, so only valid agreeing votes break it.
  always_comb begin
    fault_nxt = '0;
    for (int i = 0; i < N; i++) begin
      streak_nxt[i] = streak_q[i];
      if (clr_fault) begin
        streak_nxt[i] = '0;
      end else if (in_valid) begin
        if (!mm_nxt[i]) begin
          streak_nxt[i] = '0;
        end else if (streak_q[i] != THRESH) begin
          streak_nxt[i] = streak_q[i] + 1'b1;
        end
      end
      fault_nxt[i] = (streak_nxt[i] == THRESH);
`ifdef MAJ_VOTER_STICKY_FAULT_EN
      if (fault[i] && !clr_fault) begin
        fault_nxt[i] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    cnt_nxt = disagree_cnt;
    if (clr_fault) begin
      cnt_nxt = '0;
    end else if (in_valid && (|mm_nxt) && (disagree_cnt != CNT_MAX)) begin
      cnt_nxt = disagree_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      mismatch     <= '0;
      fault        <= '0;
      disagree_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        streak_q[i] <= '0;
      end
    end else begin
      out_valid    <= in_valid;
      mismatch     <= in_valid ? mm_nxt : '0;
      if (in_valid) begin
        out_data <= voted;
      end
      fault        <= fault_nxt;
      disagree_cnt <= cnt_nxt;
      for (int i = 0; i < N; i++) begin
        streak_q[i] <= streak_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_maj_voter_n.sv
// Bench for maj_voter_n (N=3, W=4, FAULT_THRESH=3, CNT_W=8): vector table plus hand sequences, scoreboarded per cycle.
module tb_maj_voter_n;

`ifdef MAJ_VOTER_STICKY_FAULT_EN
  localparam logic [2:0] STICKY = 3'b100;
`else
  localparam logic [2:0] STICKY = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        clr_fault;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  mismatch;
  logic [2:0]  fault;
  logic [7:0]  disagree_cnt;

  always #5 clk = ~clk;

  maj_voter_n #(.N(3), .W(4), .FAULT_THRESH(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clr_fault    (clr_fault),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .mismatch     (mismatch),
    .fault        (fault),
    .disagree_cnt (disagree_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic        clr;
    logic [11:0] dat;
    logic        ov;
    logic [3:0]  od;
    logic [2:0]  mm;
    logic [2:0]  flt;
    logic [7:0]  cnt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[13];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic c, input logic [11:0] d,
                              input logic ov, input logic [3:0] od, input logic [2:0] mm,
                              input logic [2:0] flt, input logic [7:0] cnt);
    vec_t x;
    x.rst_n = r; x.vld = v; x.clr = c; x.dat = d;
    x.ov = ov; x.od = od; x.mm = mm; x.flt = flt; x.cnt = cnt;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst_n     = v.rst_n;
    in_valid  = v.vld;
    clr_fault = v.clr;
    in_data   = v.dat;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".out_valid"},    32'(out_valid),    32'(e.ov));
      check({tag, ".out_data"},     32'(out_data),     32'(e.od));
      check({tag, ".mismatch"},     32'(mismatch),     32'(e.mm));
      check({tag, ".fault"},        32'(fault),        32'(e.flt));
      check({tag, ".disagree_cnt"}, 32'(disagree_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr_fault = 1'b0; in_data = '0;

    // data packed {ch2, ch1, ch0}
    tbl[0]  = mk(1, 1, 0, 12'h5AA, 1, 4'hA, 3'b100, 3'b000, 8'd1);
    tbl[1]  = mk(1, 0, 0, 12'h000, 0, 4'hA, 3'b000, 3'b000, 8'd1);
    tbl[2]  = mk(1, 1, 0, 12'h9AC, 1, 4'h8, 3'b111, 3'b000, 8'd2);
    tbl[3]  = mk(1, 1, 0, 12'hAAA, 1, 4'hA, 3'b000, 3'b000, 8'd2);
    tbl[4]  = mk(1, 1, 0, 12'h377, 1, 4'h7, 3'b100, 3'b000, 8'd3);
    tbl[5]  = mk(1, 0, 0, 12'h000, 0, 4'h7, 3'b000, 3'b000, 8'd3);
    tbl[6]  = mk(1, 1, 0, 12'h077, 1, 4'h7, 3'b100, 3'b000, 8'd4);
    tbl[7]  = mk(1, 0, 0, 12'h000, 0, 4'h7, 3'b000, 3'b000, 8'd4);
    tbl[8]  = mk(1, 1, 0, 12'hF77, 1, 4'h7, 3'b100, 3'b100, 8'd5);
    tbl[9]  = mk(1, 0, 0, 12'h000, 0, 4'h7, 3'b000, 3'b100, 8'd5);
    tbl[10] = mk(1, 1, 0, 12'h777, 1, 4'h7, 3'b000, STICKY, 8'd5);
    tbl[11] = mk(1, 0, 0, 12'h000, 0, 4'h7, 3'b000, STICKY, 8'd5);
    tbl[12] = mk(1, 0, 1, 12'h000, 0, 4'h7, 3'b000, 3'b000, 8'd0);

    // reset held for two edges with live random traffic
    for (int i = 0; i < 2; i++) begin
      step(mk(0, 1, 0, 12'($urandom), 0, 4'h0, 3'b000, 3'b000, 8'd0), $sformatf("reset%0d", i));
    end

    for (int i = 0; i < 13; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // back-to-back mismatches: counter saturates at 255, fault from the 3rd vote
    for (int k = 1; k <= 260; k++) begin
      step(mk(1, 1, 0, 12'h122, 1, 4'h2, 3'b100, (k >= 3) ? 3'b100 : 3'b000,
              (k >= 255) ? 8'd255 : 8'(k)), $sformatf("sat%0d", k));
    end
    step(mk(1, 1, 1, 12'h122, 1, 4'h2, 3'b100, 3'b000, 8'd0), "clr_vote");
    step(mk(1, 1, 0, 12'h122, 1, 4'h2, 3'b100, 3'b000, 8'd1), "post_clr");

    // reset mid-stream wipes the ch1 streak
    step(mk(1, 1, 0, 12'h4B4, 1, 4'h4, 3'b010, 3'b000, 8'd2), "mid_a");
    step(mk(1, 1, 0, 12'h4B4, 1, 4'h4, 3'b010, 3'b000, 8'd3), "mid_b");
    step(mk(0, 1, 0, 12'h4B4, 0, 4'h0, 3'b000, 3'b000, 8'd0), "mid_rst");
    step(mk(1, 1, 0, 12'h4B4, 1, 4'h4, 3'b010, 3'b000, 8'd1), "mid_c");
    step(mk(1, 1, 0, 12'h4B4, 1, 4'h4, 3'b010, 3'b000, 8'd2), "mid_d");
    step(mk(1, 1, 0, 12'h4B4, 1, 4'h4, 3'b010, 3'b010, 8'd3), "mid_e");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/maj_voter_n.md
Name: maj_voter_n

Overview:
- Parametrised N-way bitwise majority voter: successor to the 3-input combinational majority gate, generalised in channel count and width.
- Adds a registered output with valid qualification, per-channel mismatch detection, consecutive-mismatch fault tracking and a saturating disagreement counter.
- Sits behind redundant (TMR/NMR) datapaths. Feeds the voted word downstream and reports failing channels to the control/status logic.

Parameters:
- N, 3, number of redundant channels; must be odd and >= 3; even or smaller values fail elaboration.
- W, 8, data width per channel in bits; >= 1.
- FAULT_THRESH, 3, consecutive mismatching votes that flag a channel faulty; >= 1.
- CNT_W, 8, width of the disagreement event counter; >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data holds a vote request this cycle.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- clr_fault  input  1  clears streak counters, fault and disagree_cnt.
- out_valid  output  1  out_data/mismatch carry a new vote result.
- out_data  output  W  voted word.
- mismatch  output  N  bit i = channel i differed from the voted word on this vote.
- fault  output  N  bit i = channel i reached FAULT_THRESH consecutive mismatches.
- disagree_cnt  output  CNT_W  count of votes with any mismatch, saturating.

Behaviour:
- Reset: on a rising edge with rst_n=0, all outputs and internal state go to 0: out_valid, out_data, mismatch, fault, disagree_cnt and every streak counter. Reset overrides all other inputs, including mid-stream.
- Vote, combinational: each bit position of the voted word is 1 iff the count of 1s across the N channels at that position is >= (N+1)/2.
- Latency: 1 cycle. When in_valid=1 at edge k, the registers update at edge k:
  - out_valid=1;
  - out_data=voted word;
  - mismatch[i]=(channel i != voted word), compared over all W bits.
- Idle: when in_valid=0, out_valid=0 and mismatch=0. out_data holds its last value. Streaks, fault and disagree_cnt hold. An idle cycle does not break a streak.
- No backpressure: the block accepts a vote every cycle.
- Streak counter, one per channel, width $clog2(FAULT_THRESH+1):
  - on a valid vote with a mismatch, increments and saturates at FAULT_THRESH;
  - on a valid vote where the channel agrees, resets to 0.
- fault[i] is registered and equals (next streak[i] == FAULT_THRESH). It asserts in the same cycle as the out_valid of the FAULT_THRESH-th consecutive mismatching vote.
- disagree_cnt: increments by 1 on each valid vote where the mismatch vector is non-zero. It saturates at 2^CNT_W-1 and never wraps.
- clr_fault=1 at an edge:
  - streaks, fault and disagree_cnt become 0;
  - clr_fault wins over a simultaneous increment;
  - the vote itself (out_valid, out_data, mismatch) still proceeds normally.
- All-channel disagreement (e.g. every channel differs from the voted word) is legal. Every mismatch bit is set.

Optional Feature:
- Macro MAJ_VOTER_STICKY_FAULT_EN.
- Defined: fault[i] is sticky. Once set, it stays 1 until clr_fault or reset, even if the channel later agrees and its streak returns to 0.
- Undefined: fault[i] tracks the streak and drops on the first agreeing vote.
- No other behaviour changes.

Test Plan:
All scenarios use N=3, W=4, FAULT_THRESH=3, CNT_W=8.
- Reset: hold rst_n=0 for 2 edges with random inputs and in_valid=1 -> out_valid=0, out_data=0x0, mismatch=0, fault=0, disagree_cnt=0.
- Single-channel error: in_valid=1, ch0=0xA, ch1=0xA, ch2=0x5 -> next cycle out_valid=1, out_data=0xA, mismatch=3'b100, disagree_cnt=1. One idle cycle later: out_valid=0, out_data=0xA.
- Bitwise vote: ch0=0xC, ch1=0xA, ch2=0x9 -> out_data=0x8, mismatch=3'b111, disagree_cnt incremented by 1.
- Fault threshold: three valid votes with ch2 wrong, with idle cycles between them -> fault=3'b100 on the 3rd result. Then one agreeing vote:
  - non-sticky -> fault=0;
  - MAJ_VOTER_STICKY_FAULT_EN -> fault stays 3'b100 until a clr_fault pulse clears it to 0.
- Saturation and clear: 260 back-to-back mismatching votes -> disagree_cnt=255, with no wrap. Then clr_fault together with a mismatching vote -> disagree_cnt=0, fault=0, out_valid=1 with a correct out_data.
- Reset mid-operation: after 2 mismatching ch1 votes, drop rst_n for 1 edge. Then 2 more ch1 mismatches -> fault[1]=0. A 3rd mismatch -> fault[1]=1.
